// File: rtl/tri_regfile_pkg.sv
// -----------------------------------------------------------------------------
// tri_regfile_pkg
//   Shared constants for the processor register file.
//   WORD_W : default datapath word width (10 bits).
// -----------------------------------------------------------------------------
package tri_regfile_pkg;

    localparam int WORD_W = 10;

endpackage : tri_regfile_pkg

// File: rtl/triStateBuffer.sv
// -----------------------------------------------------------------------------
// triStateBuffer
//   Drives a W-bit bus when enabled and releases it (all 'z) otherwise.
//   Ports:
//     en_i : output enable
//     d_i  : data to place on the bus
//     q_o  : bus output, 'z when en_i=0
// -----------------------------------------------------------------------------
module triStateBuffer #(
    parameter int W = 10
) (
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output wire  [W-1:0] q_o
);

    assign q_o = en_i ? d_i : {W{1'bz}};

endmodule : triStateBuffer

// File: rtl/tri_regfile.sv
// -----------------------------------------------------------------------------
// tri_regfile
//   Bank of NREG registers, N bits each, with one write port and two
//   independent tri-state read ports feeding the shared operand buses.
//   Tracks which registers have been written since reset and raises a sticky
//   error when an enabled read targets an unwritten or out-of-range register.
//   All state updates on the falling edge of CLKb; Reset is async active-high.
//
//   Ports:
//     CLKb   : clock, state updates on negedge
//     Reset  : asynchronous active-high reset
//     D      : write data
//     Rin    : write enable
//     WAddr  : write address
//     Rout0  : read port 0 output enable
//     RAddr0 : read port 0 address
//     Rout1  : read port 1 output enable
//     RAddr1 : read port 1 address
//     Q0/Q1  : read data, 'z when the matching Rout is low
//     Valid  : bit i set once register i has been written since reset
//     RdErr  : sticky read-of-unwritten / out-of-range flag
//
//   Bus contention between this block and other bus drivers is not resolved
//   here; the controller keeps the Rout enables mutually exclusive.
// -----------------------------------------------------------------------------
module tri_regfile
    import tri_regfile_pkg::*;
#(
    parameter int N       = WORD_W,
    parameter int NREG    = 8,
    parameter int BYPASS  = 0,
    parameter int ZERO_R0 = 0
) (
    input  logic                    CLKb,
    input  logic                    Reset,
    input  logic [N-1:0]            D,
    input  logic                    Rin,
    input  logic [$clog2(NREG)-1:0] WAddr,
    input  logic                    Rout0,
    input  logic [$clog2(NREG)-1:0] RAddr0,
    input  logic                    Rout1,
    input  logic [$clog2(NREG)-1:0] RAddr1,
    output wire  [N-1:0]            Q0,
    output wire  [N-1:0]            Q1,
    output logic [NREG-1:0]         Valid,
    output logic                    RdErr
);

    localparam int AW = $clog2(NREG);
    // NREG held one bit wider than an address so that range checks on
    // non-power-of-two banks compare like widths.
    localparam logic [AW:0] NREG_W = NREG[AW:0];

    logic [N-1:0]    regs_q [NREG];
    logic [NREG-1:0] valid_q;
    logic            rderr_q;
    logic            rderr_d;

    logic            wr_en;
    logic [NREG-1:0] valid_vec;

    logic [AW-1:0]   raddr   [2];
    logic            rout    [2];
    logic [N-1:0]    rd_data [2];
    logic [1:0]      rd_bad;

    assign raddr[0] = RAddr0;
    assign raddr[1] = RAddr1;
    assign rout[0]  = Rout0;
    assign rout[1]  = Rout1;

    // Write qualifies only in range, outside reset, and never into a
    // hard-wired zero register.
    assign wr_en = Rin && !Reset
                && ({1'b0, WAddr} < NREG_W)
                && !((ZERO_R0 != 0) && (WAddr == '0));

    // A hard-wired zero register always counts as written.
    assign valid_vec = valid_q | {{(NREG-1){1'b0}}, (ZERO_R0 != 0)};
    assign Valid     = valid_vec;
    assign RdErr     = rderr_q;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic in_range;
        logic bypass;

        always_comb begin
            in_range   = ({1'b0, raddr[p]} < NREG_W);
            // wr_en already excludes reset, out-of-range and the zero register.
            bypass     = (BYPASS != 0) && wr_en && (WAddr == raddr[p]);
            rd_data[p] = '0;
            if (Reset) begin
                rd_data[p] = '0;
            end else if (bypass) begin
                rd_data[p] = D;
            end else if (in_range && !((ZERO_R0 != 0) && (raddr[p] == '0))) begin
                rd_data[p] = regs_q[raddr[p]];
            end
            // Bypassed reads deliver the fresh value, so they are never errors.
            rd_bad[p] = rout[p] && !bypass && (!in_range || !valid_vec[raddr[p]]);
        end
    end

    // Error check looks at Valid as it stood before this edge's write.
    assign rderr_d = rderr_q | (|rd_bad);

    always_ff @(negedge CLKb or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            valid_q <= '0;
            rderr_q <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[WAddr]  <= D;
                valid_q[WAddr] <= 1'b1;
            end
            rderr_q <= rderr_d;
        end
    end

    triStateBuffer #(.W(N)) u_tsb0 (
        .en_i (Rout0),
        .d_i  (rd_data[0]),
        .q_o  (Q0)
    );

    triStateBuffer #(.W(N)) u_tsb1 (
        .en_i (Rout1),
        .d_i  (rd_data[1]),
        .q_o  (Q1)
    );

endmodule : tri_regfile

// File: tb/tb_tri_regfile.sv
module tb_tri_regfile;

  logic       CLKb;
  logic       Reset;
  logic [9:0] D;
  logic       Rin;
  logic [2:0] WAddr;
  logic       Rout0;
  logic [2:0] RAddr0;
  logic       Rout1;
  logic [2:0] RAddr1;

  // second driver on the port-1 bus of the main instance, used to prove release
  logic       tb_en;
  logic [9:0] tb_val;

  wire  [9:0] q0_a, q1_bus;
  logic [7:0] valid_a;
  logic       rderr_a;

  wire  [9:0] q0_b, q1_b;
  logic [7:0] valid_b;
  logic       rderr_b;

  wire  [9:0] q0_z, q1_z;
  logic [7:0] valid_z;
  logic       rderr_z;

  wire  [9:0] q0_6, q1_6;
  logic [5:0] valid_6;
  logic       rderr_6;

  int n_checks;
  int n_fail;

  assign q1_bus = tb_en ? tb_val : 10'bz;

  // main instance: N=10, NREG=8, no bypass, no zero register
  tri_regfile #(.N(10), .NREG(8), .BYPASS(0), .ZERO_R0(0)) u_dut (
    .CLKb(CLKb), .Reset(Reset), .D(D), .Rin(Rin), .WAddr(WAddr),
    .Rout0(Rout0), .RAddr0(RAddr0), .Rout1(Rout1), .RAddr1(RAddr1),
    .Q0(q0_a), .Q1(q1_bus), .Valid(valid_a), .RdErr(rderr_a)
  );

  tri_regfile #(.N(10), .NREG(8), .BYPASS(1), .ZERO_R0(0)) u_byp (
    .CLKb(CLKb), .Reset(Reset), .D(D), .Rin(Rin), .WAddr(WAddr),
    .Rout0(Rout0), .RAddr0(RAddr0), .Rout1(Rout1), .RAddr1(RAddr1),
    .Q0(q0_b), .Q1(q1_b), .Valid(valid_b), .RdErr(rderr_b)
  );

  tri_regfile #(.N(10), .NREG(8), .BYPASS(0), .ZERO_R0(1)) u_zr0 (
    .CLKb(CLKb), .Reset(Reset), .D(D), .Rin(Rin), .WAddr(WAddr),
    .Rout0(Rout0), .RAddr0(RAddr0), .Rout1(Rout1), .RAddr1(RAddr1),
    .Q0(q0_z), .Q1(q1_z), .Valid(valid_z), .RdErr(rderr_z)
  );

  tri_regfile #(.N(10), .NREG(6), .BYPASS(0), .ZERO_R0(0)) u_n6 (
    .CLKb(CLKb), .Reset(Reset), .D(D), .Rin(Rin), .WAddr(WAddr),
    .Rout0(Rout0), .RAddr0(RAddr0), .Rout1(Rout1), .RAddr1(RAddr1),
    .Q0(q0_6), .Q1(q1_6), .Valid(valid_6), .RdErr(rderr_6)
  );

  // clock / reset block
  initial begin
    CLKb = 1'b1;
    forever #5 CLKb = ~CLKb;
  end

  // driver tasks
  task automatic tick();
    @(negedge CLKb);
    #1;
  endtask

  task automatic idle_inputs();
    Rin = 1'b0; WAddr = '0; D = '0;
    Rout0 = 1'b0; RAddr0 = '0;
    Rout1 = 1'b0; RAddr1 = '0;
  endtask

  // reset pulse placed between falling edges
  task automatic pulse_reset();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_inputs();
    tick();
    Rout0 = 1'b1; RAddr0 = 3'd3;
    #1;
    n_checks++;
    if (q0_a !== 10'h000) begin n_fail++; $display("FAIL reset_q0_in_reset: got %h expected %h", q0_a, 10'h000); end
    n_checks++;
    if (valid_a !== 8'h00) begin n_fail++; $display("FAIL reset_valid: got %h expected %h", valid_a, 8'h00); end
    n_checks++;
    if (valid_z !== 8'h01) begin n_fail++; $display("FAIL reset_valid_zr0: got %h expected %h", valid_z, 8'h01); end
    Reset = 1'b0;
    #1;
    n_checks++;
    if (rderr_a !== 1'b0) begin n_fail++; $display("FAIL reset_rderr: got %b expected %b", rderr_a, 1'b0); end
    n_checks++;
    if (q0_a !== 10'h000) begin n_fail++; $display("FAIL reset_q0_read: got %h expected %h", q0_a, 10'h000); end
    tick();
    n_checks++;
    if (rderr_a !== 1'b1) begin n_fail++; $display("FAIL reset_rderr_unwritten: got %b expected %b", rderr_a, 1'b1); end
    // port 1 disabled: bus must follow the other driver
    tb_val = 10'h155; tb_en = 1'b1;
    #1;
    n_checks++;
    if (q1_bus !== 10'h155) begin n_fail++; $display("FAIL reset_q1_release: got %h expected %h", q1_bus, 10'h155); end
    tb_en = 1'b0;
    idle_inputs();
  endtask

  task automatic test_write_read();
    pulse_reset();
    Rin = 1'b1; WAddr = 3'd5; D = 10'h2A5;
    tick();
    Rin = 1'b0;
    Rout0 = 1'b1; RAddr0 = 3'd5;
    Rout1 = 1'b1; RAddr1 = 3'd5;
    #1;
    n_checks++;
    if (q0_a !== 10'h2A5) begin n_fail++; $display("FAIL wr_q0: got %h expected %h", q0_a, 10'h2A5); end
    n_checks++;
    if (q1_bus !== 10'h2A5) begin n_fail++; $display("FAIL wr_q1: got %h expected %h", q1_bus, 10'h2A5); end
    n_checks++;
    if (valid_a !== 8'h20) begin n_fail++; $display("FAIL wr_valid: got %h expected %h", valid_a, 8'h20); end
    n_checks++;
    if (valid_z !== 8'h21) begin n_fail++; $display("FAIL wr_valid_zr0: got %h expected %h", valid_z, 8'h21); end
    tick();
    n_checks++;
    if (rderr_a !== 1'b0) begin n_fail++; $display("FAIL wr_rderr: got %b expected %b", rderr_a, 1'b0); end
    // release port 1 while its register holds data
    Rout1 = 1'b0;
    tb_val = 10'h155; tb_en = 1'b1;
    #1;
    n_checks++;
    if (q1_bus !== 10'h155) begin n_fail++; $display("FAIL wr_q1_release: got %h expected %h", q1_bus, 10'h155); end
    tb_en = 1'b0;
    idle_inputs();
  endtask

  task automatic test_bypass();
    Rin = 1'b1; WAddr = 3'd2; D = 10'h011;
    tick();
    Rin = 1'b1; WAddr = 3'd2; D = 10'h3FF;
    Rout0 = 1'b1; RAddr0 = 3'd2;
    #1;
    n_checks++;
    if (q0_a !== 10'h011) begin n_fail++; $display("FAIL byp0_before_edge: got %h expected %h", q0_a, 10'h011); end
    n_checks++;
    if (q0_b !== 10'h3FF) begin n_fail++; $display("FAIL byp1_before_edge: got %h expected %h", q0_b, 10'h3FF); end
    tick();
    Rin = 1'b0;
    #1;
    n_checks++;
    if (q0_a !== 10'h3FF) begin n_fail++; $display("FAIL byp0_after_edge: got %h expected %h", q0_a, 10'h3FF); end
    n_checks++;
    if (q0_b !== 10'h3FF) begin n_fail++; $display("FAIL byp1_after_edge: got %h expected %h", q0_b, 10'h3FF); end
    n_checks++;
    if (rderr_a !== 1'b0) begin n_fail++; $display("FAIL byp_rderr_valid_read: got %b expected %b", rderr_a, 1'b0); end
    // read-while-write of an unwritten register: error only without bypass
    idle_inputs();
    pulse_reset();
    Rin = 1'b1; WAddr = 3'd4; D = 10'h0AB;
    Rout0 = 1'b1; RAddr0 = 3'd4;
    tick();
    Rin = 1'b0; Rout0 = 1'b0;
    #1;
    n_checks++;
    if (rderr_a !== 1'b1) begin n_fail++; $display("FAIL byp0_rderr_before_write: got %b expected %b", rderr_a, 1'b1); end
    n_checks++;
    if (rderr_b !== 1'b0) begin n_fail++; $display("FAIL byp1_rderr_bypassed: got %b expected %b", rderr_b, 1'b0); end
    idle_inputs();
  endtask

  task automatic test_zero_r0();
    pulse_reset();
    Rin = 1'b1; WAddr = 3'd0; D = 10'h155;
    tick();
    Rin = 1'b0;
    Rout0 = 1'b1; RAddr0 = 3'd0;
    #1;
    n_checks++;
    if (q0_z !== 10'h000) begin n_fail++; $display("FAIL zr0_q0: got %h expected %h", q0_z, 10'h000); end
    n_checks++;
    if (q0_a !== 10'h155) begin n_fail++; $display("FAIL zr0_plain_q0: got %h expected %h", q0_a, 10'h155); end
    n_checks++;
    if (valid_z !== 8'h01) begin n_fail++; $display("FAIL zr0_valid: got %h expected %h", valid_z, 8'h01); end
    tick();
    n_checks++;
    if (rderr_z !== 1'b0) begin n_fail++; $display("FAIL zr0_rderr: got %b expected %b", rderr_z, 1'b0); end
    idle_inputs();
  endtask

  task automatic test_nreg6();
    pulse_reset();
    Rin = 1'b1; WAddr = 3'd7; D = 10'h3C3;
    tick();
    Rin = 1'b0;
    n_checks++;
    if (valid_6 !== 6'h00) begin n_fail++; $display("FAIL n6_valid_oob: got %h expected %h", valid_6, 6'h00); end
    Rout1 = 1'b1; RAddr1 = 3'd7;
    #1;
    n_checks++;
    if (q1_6 !== 10'h000) begin n_fail++; $display("FAIL n6_q1_oob: got %h expected %h", q1_6, 10'h000); end
    n_checks++;
    if (q1_bus !== 10'h3C3) begin n_fail++; $display("FAIL n8_q1_r7: got %h expected %h", q1_bus, 10'h3C3); end
    n_checks++;
    if (rderr_6 !== 1'b0) begin n_fail++; $display("FAIL n6_rderr_before_edge: got %b expected %b", rderr_6, 1'b0); end
    tick();
    n_checks++;
    if (rderr_6 !== 1'b1) begin n_fail++; $display("FAIL n6_rderr_oob: got %b expected %b", rderr_6, 1'b1); end
    Rout1 = 1'b0;
    Rin = 1'b1; WAddr = 3'd5; D = 10'h0F0;
    tick();
    Rin = 1'b0;
    Rout0 = 1'b1; RAddr0 = 3'd5;
    #1;
    n_checks++;
    if (q0_6 !== 10'h0F0) begin n_fail++; $display("FAIL n6_q0_top_reg: got %h expected %h", q0_6, 10'h0F0); end
    n_checks++;
    if (valid_6 !== 6'h20) begin n_fail++; $display("FAIL n6_valid_top_reg: got %h expected %h", valid_6, 6'h20); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    Rin = 1'b1; WAddr = 3'd1; D = 10'h123;
    Rout1 = 1'b1; RAddr1 = 3'd6;
    tick();
    Rin = 1'b0; Rout1 = 1'b0;
    Rout0 = 1'b1; RAddr0 = 3'd1;
    #1;
    n_checks++;
    if (q0_a !== 10'h123) begin n_fail++; $display("FAIL areset_pre_q0: got %h expected %h", q0_a, 10'h123); end
    n_checks++;
    if (rderr_a !== 1'b1) begin n_fail++; $display("FAIL areset_pre_rderr: got %b expected %b", rderr_a, 1'b1); end
    // mid-cycle reset with a write pending
    Rin = 1'b1; WAddr = 3'd1; D = 10'h3AA;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (q0_a !== 10'h000) begin n_fail++; $display("FAIL areset_q0: got %h expected %h", q0_a, 10'h000); end
    n_checks++;
    if (valid_a !== 8'h00) begin n_fail++; $display("FAIL areset_valid: got %h expected %h", valid_a, 8'h00); end
    n_checks++;
    if (rderr_a !== 1'b0) begin n_fail++; $display("FAIL areset_rderr: got %b expected %b", rderr_a, 1'b0); end
    n_checks++;
    if (q0_b !== 10'h000) begin n_fail++; $display("FAIL areset_bypass_q0: got %h expected %h", q0_b, 10'h000); end
    tick();
    n_checks++;
    if (q0_a !== 10'h000) begin n_fail++; $display("FAIL areset_write_blocked: got %h expected %h", q0_a, 10'h000); end
    Rin = 1'b0;
    Reset = 1'b0;
    #1;
    n_checks++;
    if (q0_a !== 10'h000) begin n_fail++; $display("FAIL areset_post_q0: got %h expected %h", q0_a, 10'h000); end
    n_checks++;
    if (valid_a !== 8'h00) begin n_fail++; $display("FAIL areset_post_valid: got %h expected %h", valid_a, 8'h00); end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tb_en    = 1'b0;
    tb_val   = '0;
    Reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_r0();
    test_nreg6();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tri_regfile
